lfsr_step: RTL and testbench
============================

Name: lfsr_step

Overview:
- Parameterized LFSR engine. Advances a caller-supplied LFSR state by DATA_WIDTH bit-steps, consuming one data bit per step.
- Returns the new state and the per-bit output stream, registered with one-cycle latency.
- Used for CRC generation/checking (e.g. the Ethernet FCS, CRC-32) and for additive or self-synchronizing scramblers.
- Stateless between calls: the caller owns and feeds back the state.

Parameters:
- LFSR_WIDTH, 31: state width W, 2..128.
- LFSR_POLY, 31'h10000001: polynomial without the x^W term; bit 0 is the x^0 coefficient.
- LFSR_CONFIG, "FIBONACCI": "FIBONACCI" or "GALOIS".
- LFSR_FEED_FORWARD, 0: Fibonacci only. 1 = shift data_in (descrambler); 0 = shift output (scrambler).
- REVERSE, 0: 1 = bit-reflected operation (LSB-first data, reflected state).
- DATA_WIDTH, 8: data bits per call, 1..256.
- STYLE, "AUTO": "AUTO", "LOOP" or "REDUCTION". Implementation style only; results must be identical. Any other value is an elaboration error.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  data_in and state_in are sampled this cycle.
- data_in  in  DATA_WIDTH  input data bits.
- state_in  in  LFSR_WIDTH  current LFSR state.
- out_valid  out  1  registered; high one cycle after an accepted in_valid.
- data_out  out  DATA_WIDTH  registered per-bit output.
- state_out  out  LFSR_WIDTH  registered next state.

Behaviour:
- Reset: out_valid=0, data_out=0, state_out=0. Reset has priority over in_valid in the same cycle.
- Latency 1: when in_valid=1 at edge N, the edge-N registers hold the result and out_valid=1 after edge N.
- When in_valid=0, out_valid=0 and data_out/state_out hold their values.
- No backpressure. Back-to-back in_valid is accepted every cycle.
- The core is combinational. With REVERSE=0, bits are processed MSB first: d = data_in[DATA_WIDTH-1] first, result bit written at the same index.
- With REVERSE=1:
  - data bits are processed LSB first (data_in[0] first);
  - state_in is bit-reversed before stepping and state_out is bit-reversed after;
  - the data_out bit index matches the consumed data bit.
- GALOIS step, for state s and bit d:
  - fb = s[W-1]^d;
  - s = (s<<1) ^ (fb ? LFSR_POLY : 0);
  - out bit = fb.
  - LFSR_FEED_FORWARD is ignored.
- FIBONACCI step:
  - tap mask T = {LFSR_POLY[0], LFSR_POLY[W-1:1]};
  - f = XOR-reduce(s & T);
  - out bit = d^f;
  - s = {s[W-2:0], LFSR_FEED_FORWARD ? d : out bit}.
- The result after DATA_WIDTH steps is a pure XOR (GF(2)) function of state_in and data_in. LOOP style iterates the steps; REDUCTION style precomputes per-output masks at elaboration. Both must match bit-exactly.
- Invalid LFSR_CONFIG, W<2, or DATA_WIDTH<1: elaboration error.
- Ethernet CRC usage:
  - parameters W=32, POLY=32'h04C11DB7, GALOIS, REVERSE=1, DATA_WIDTH=8;
  - start state 32'hFFFFFFFF;
  - FCS = ~final state, transmitted LSB byte first.
- X-free: inputs that are not X never produce an X output.

Test Plan:
- Ethernet CRC configuration, state_in=32'hFFFFFFFF, data_in=8'h00, in_valid pulse -> one cycle later out_valid=1, state_out=32'h2DFD1072.
- Same configuration, feed "123456789" (8'h31..8'h39) one byte per cycle, feeding state_out back as state_in, start FFFFFFFF -> final ~state = 32'hCBF43926.
- Fibonacci scrambler (W=58, POLY=58'h8000000001, FF=0, DATA_WIDTH=64) feeding a descrambler instance (FF=1) with the same initial state -> descrambler data_out equals the original data for 100 random words.
- Compare STYLE="LOOP" and STYLE="REDUCTION" instances on 1000 random state/data vectors across GALOIS, FIBONACCI and REVERSE=0/1 -> identical state_out and data_out every cycle.
- Assert rst together with in_valid=1 -> out_valid=0, outputs 0 next cycle. Deassert rst -> the next in_valid produces a correct result after 1 cycle.
- in_valid low for 5 cycles between transactions -> out_valid low and outputs stable throughout.

Source files
------------

// File: rtl/lfsr_step.sv
`default_nettype none
//==============================================================================
// Module   : lfsr_step
// Purpose  : Advances a caller-owned LFSR state by DATA_WIDTH bit-steps
//            (Galois or Fibonacci) with a one-cycle registered result.
// Revision : 1.0 - initial release
//==============================================================================
module lfsr_step #(
  parameter int                    LFSR_WIDTH        = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = LFSR_WIDTH'(31'h10000001),
  parameter string                 LFSR_CONFIG       = "FIBONACCI",
  parameter int                    LFSR_FEED_FORWARD = 0,
  parameter int                    REVERSE           = 0,
  parameter int                    DATA_WIDTH        = 8,
  parameter string                 STYLE             = "AUTO"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LFSR_WIDTH-1:0] state_out
);

  localparam int c_w = LFSR_WIDTH;
  localparam int c_d = DATA_WIDTH;
  localparam int c_m = c_w + c_d;

  localparam bit c_galois = (LFSR_CONFIG == "GALOIS");
  localparam bit c_fib    = (LFSR_CONFIG == "FIBONACCI");
  localparam bit c_ff     = (LFSR_FEED_FORWARD != 0);
  localparam bit c_rev    = (REVERSE != 0);

  // Fibonacci tap mask: the x^0 coefficient taps the oldest state bit.
  localparam logic [c_w-1:0] c_taps = {LFSR_POLY[0], LFSR_POLY[c_w-1:1]};

  if (!(c_galois || c_fib)) begin : g_bad_config
    $error("lfsr_step: LFSR_CONFIG must be \"FIBONACCI\" or \"GALOIS\"");
  end
  if (LFSR_WIDTH < 2 || LFSR_WIDTH > 128) begin : g_bad_width
    $error("lfsr_step: LFSR_WIDTH must be in 2..128");
  end
  if (DATA_WIDTH < 1 || DATA_WIDTH > 256) begin : g_bad_data_width
    $error("lfsr_step: DATA_WIDTH must be in 1..256");
  end
  if (!(STYLE == "AUTO" || STYLE == "LOOP" || STYLE == "REDUCTION")) begin : g_bad_style
    $error("lfsr_step: STYLE must be \"AUTO\", \"LOOP\" or \"REDUCTION\"");
  end

  // Full bit-serial evaluation; input and result are packed as {data, state}.
  function automatic logic [c_m-1:0] lfsr_calc(input logic [c_m-1:0] vin);
    logic [c_w-1:0] s;
    logic [c_w-1:0] s_out;
    logic [c_d-1:0] din;
    logic [c_d-1:0] dout;
    logic           d;
    logic           fb;
    int             idx;
    din  = vin[c_m-1:c_w];
    dout = '0;
    for (int i = 0; i < c_w; i++) begin
      s[i] = c_rev ? vin[c_w-1-i] : vin[i];
    end
    for (int k = 0; k < c_d; k++) begin
      idx = c_rev ? k : c_d - 1 - k;
      d   = din[idx];
      if (c_galois) begin
        fb = s[c_w-1] ^ d;
        s  = (s << 1) ^ (fb ? LFSR_POLY : '0);
      end else begin
        fb = d ^ (^(s & c_taps));
        s  = {s[c_w-2:0], c_ff ? d : fb};
      end
      dout[idx] = fb;
    end
    for (int i = 0; i < c_w; i++) begin
      s_out[i] = c_rev ? s[c_w-1-i] : s[i];
    end
    return {dout, s_out};
  endfunction

  logic [c_m-1:0] w_in;
  logic [c_m-1:0] w_result;

  assign w_in = {data_in, state_in};

  if (STYLE == "LOOP") begin : g_loop
    assign w_result = lfsr_calc(w_in);
  end else begin : g_reduction
    // The map is linear over GF(2): each input bit contributes a fixed column,
    // precomputed by stepping a unit vector at elaboration.
    logic [c_m-1:0] w_terms [c_m];
    logic [c_m-1:0] w_red;

    for (genvar j = 0; j < c_m; j++) begin : g_col
      localparam logic [c_m-1:0] c_unit = {{(c_m-1){1'b0}}, 1'b1} << j;
      localparam logic [c_m-1:0] c_col  = lfsr_calc(c_unit);
      assign w_terms[j] = w_in[j] ? c_col : '0;
    end

    always_comb begin
      w_red = '0;
      for (int j = 0; j < c_m; j++) begin
        w_red = w_red ^ w_terms[j];
      end
    end

    assign w_result = w_red;
  end

  logic           r_valid;
  logic [c_d-1:0] r_data;
  logic [c_w-1:0] r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_state <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_data  <= w_result[c_m-1:c_w];
        r_state <= w_result[c_w-1:0];
      end
    end
  end

  assign out_valid = r_valid;
  assign data_out  = r_data;
  assign state_out = r_state;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_step.sv
`default_nettype none
//==============================================================================
// Module   : tb_lfsr_step
// Purpose  : Self-checking bench for lfsr_step (CRC-32, scrambler pair,
//            LOOP/REDUCTION equivalence, reset and idle behaviour).
// Revision : 1.0 - initial release
//==============================================================================
module tb_lfsr_step;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Ethernet CRC-32 configuration
  logic        crc_iv;
  logic [7:0]  crc_di;
  logic [31:0] crc_si;
  logic        crc_ov;
  logic [7:0]  crc_do;
  logic [31:0] crc_so;

  lfsr_step #(.LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7), .LFSR_CONFIG("GALOIS"),
              .LFSR_FEED_FORWARD(0), .REVERSE(1), .DATA_WIDTH(8), .STYLE("AUTO"))
  u_crc (.clk(clk), .rst(rst), .in_valid(crc_iv), .data_in(crc_di), .state_in(crc_si),
         .out_valid(crc_ov), .data_out(crc_do), .state_out(crc_so));

  // x^58 + x^39 + 1 scrambler and its self-synchronizing descrambler
  logic        scr_iv, dsc_iv;
  logic [63:0] scr_di, dsc_di, scr_do, dsc_do;
  logic [57:0] scr_si, dsc_si, scr_so, dsc_so;
  logic        scr_ov, dsc_ov;

  lfsr_step #(.LFSR_WIDTH(58), .LFSR_POLY(58'h8000000001), .LFSR_CONFIG("FIBONACCI"),
              .LFSR_FEED_FORWARD(0), .REVERSE(0), .DATA_WIDTH(64), .STYLE("AUTO"))
  u_scr (.clk(clk), .rst(rst), .in_valid(scr_iv), .data_in(scr_di), .state_in(scr_si),
         .out_valid(scr_ov), .data_out(scr_do), .state_out(scr_so));

  lfsr_step #(.LFSR_WIDTH(58), .LFSR_POLY(58'h8000000001), .LFSR_CONFIG("FIBONACCI"),
              .LFSR_FEED_FORWARD(1), .REVERSE(0), .DATA_WIDTH(64), .STYLE("LOOP"))
  u_dsc (.clk(clk), .rst(rst), .in_valid(dsc_iv), .data_in(dsc_di), .state_in(dsc_si),
         .out_valid(dsc_ov), .data_out(dsc_do), .state_out(dsc_so));

  // LOOP / REDUCTION pairs sharing one random stimulus
  logic         pv;
  logic [255:0] pd;
  logic [127:0] ps;

  logic a_lv, a_rv, b_lv, b_rv, c_lv, c_rv, d_lv, d_rv;
  logic [7:0]  a_ld, a_rd;
  logic [15:0] a_ls, a_rs;
  logic [23:0] b_ld, b_rd;
  logic [31:0] b_ls, b_rs;
  logic [11:0] c_ld, c_rd;
  logic [6:0]  c_ls, c_rs;
  logic [15:0] d_ld, d_rd;
  logic [22:0] d_ls, d_rs;

  lfsr_step #(.LFSR_WIDTH(16), .LFSR_POLY(16'h1021), .LFSR_CONFIG("GALOIS"),
              .LFSR_FEED_FORWARD(0), .REVERSE(0), .DATA_WIDTH(8), .STYLE("LOOP"))
  u_a_loop (.clk(clk), .rst(rst), .in_valid(pv), .data_in(pd[7:0]), .state_in(ps[15:0]),
            .out_valid(a_lv), .data_out(a_ld), .state_out(a_ls));
  lfsr_step #(.LFSR_WIDTH(16), .LFSR_POLY(16'h1021), .LFSR_CONFIG("GALOIS"),
              .LFSR_FEED_FORWARD(0), .REVERSE(0), .DATA_WIDTH(8), .STYLE("REDUCTION"))
  u_a_red (.clk(clk), .rst(rst), .in_valid(pv), .data_in(pd[7:0]), .state_in(ps[15:0]),
           .out_valid(a_rv), .data_out(a_rd), .state_out(a_rs));

  lfsr_step #(.LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7), .LFSR_CONFIG("GALOIS"),
              .LFSR_FEED_FORWARD(0), .REVERSE(1), .DATA_WIDTH(24), .STYLE("LOOP"))
  u_b_loop (.clk(clk), .rst(rst), .in_valid(pv), .data_in(pd[23:0]), .state_in(ps[31:0]),
            .out_valid(b_lv), .data_out(b_ld), .state_out(b_ls));
  lfsr_step #(.LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7), .LFSR_CONFIG("GALOIS"),
              .LFSR_FEED_FORWARD(0), .REVERSE(1), .DATA_WIDTH(24), .STYLE("REDUCTION"))
  u_b_red (.clk(clk), .rst(rst), .in_valid(pv), .data_in(pd[23:0]), .state_in(ps[31:0]),
           .out_valid(b_rv), .data_out(b_rd), .state_out(b_rs));

  lfsr_step #(.LFSR_WIDTH(7), .LFSR_POLY(7'h41), .LFSR_CONFIG("FIBONACCI"),
              .LFSR_FEED_FORWARD(0), .REVERSE(0), .DATA_WIDTH(12), .STYLE("LOOP"))
  u_c_loop (.clk(clk), .rst(rst), .in_valid(pv), .data_in(pd[11:0]), .state_in(ps[6:0]),
            .out_valid(c_lv), .data_out(c_ld), .state_out(c_ls));
  lfsr_step #(.LFSR_WIDTH(7), .LFSR_POLY(7'h41), .LFSR_CONFIG("FIBONACCI"),
              .LFSR_FEED_FORWARD(0), .REVERSE(0), .DATA_WIDTH(12), .STYLE("REDUCTION"))
  u_c_red (.clk(clk), .rst(rst), .in_valid(pv), .data_in(pd[11:0]), .state_in(ps[6:0]),
           .out_valid(c_rv), .data_out(c_rd), .state_out(c_rs));

  lfsr_step #(.LFSR_WIDTH(23), .LFSR_POLY(23'h000021), .LFSR_CONFIG("FIBONACCI"),
              .LFSR_FEED_FORWARD(1), .REVERSE(1), .DATA_WIDTH(16), .STYLE("LOOP"))
  u_d_loop (.clk(clk), .rst(rst), .in_valid(pv), .data_in(pd[15:0]), .state_in(ps[22:0]),
            .out_valid(d_lv), .data_out(d_ld), .state_out(d_ls));
  lfsr_step #(.LFSR_WIDTH(23), .LFSR_POLY(23'h000021), .LFSR_CONFIG("FIBONACCI"),
              .LFSR_FEED_FORWARD(1), .REVERSE(1), .DATA_WIDTH(16), .STYLE("REDUCTION"))
  u_d_red (.clk(clk), .rst(rst), .in_valid(pv), .data_in(pd[15:0]), .state_in(ps[22:0]),
           .out_valid(d_rv), .data_out(d_rd), .state_out(d_rs));

  // Reference model. Galois: polynomial long division of s*x^d + data*x^w by
  // x^w + poly (quotient = output stream). Fibonacci: recurrence over the
  // history of shifted-in bits.
  function automatic void model(input int w, input int d, input logic [127:0] poly,
                                input bit galois, input bit ff, input bit rev,
                                input logic [255:0] din, input logic [127:0] sin,
                                output logic [255:0] dout, output logic [127:0] sout);
    bit dseq [256];
    bit obit [256];
    bit sint [128];
    bit divd [384];
    bit hist [384];
    bit f;
    for (int k = 0; k < d; k++) dseq[k] = rev ? din[k] : din[d-1-k];
    for (int i = 0; i < w; i++) sint[i] = rev ? sin[w-1-i] : sin[i];
    if (galois) begin
      for (int p = 0; p < 384; p++) divd[p] = 1'b0;
      for (int i = 0; i < w; i++) divd[d+i] = sint[i];
      for (int k = 0; k < d; k++) divd[w+d-1-k] ^= dseq[k];
      for (int p = w + d - 1; p >= w; p--) begin
        obit[w+d-1-p] = divd[p];
        if (divd[p]) begin
          divd[p] = 1'b0;
          for (int i = 0; i < w; i++) divd[p-w+i] ^= poly[i];
        end
      end
      for (int i = 0; i < w; i++) sint[i] = divd[i];
    end else begin
      for (int i = 0; i < w; i++) hist[w-1-i] = sint[i];
      for (int k = 0; k < d; k++) begin
        f = 1'b0;
        for (int i = 0; i < w; i++) if (poly[(i+1)%w]) f ^= hist[w+k-1-i];
        obit[k]   = dseq[k] ^ f;
        hist[w+k] = ff ? dseq[k] : obit[k];
      end
      for (int i = 0; i < w; i++) sint[i] = hist[w+d-1-i];
    end
    dout = '0;
    sout = '0;
    for (int k = 0; k < d; k++) dout[rev ? k : d-1-k] = obit[k];
    for (int i = 0; i < w; i++) sout[i] = rev ? sint[w-1-i] : sint[i];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (crc_ov !== 1'b0) begin errors++; $display("FAIL reset_crc_valid: got %b expected 0", crc_ov); end
    checks++;
    if (crc_so !== 32'h0 || crc_do !== 8'h0) begin
      errors++; $display("FAIL reset_crc_outputs: got state %h data %h expected 0", crc_so, crc_do);
    end
    checks++;
    if (scr_ov !== 1'b0 || scr_so !== 58'h0 || scr_do !== 64'h0) begin
      errors++; $display("FAIL reset_scr: got v %b state %h data %h expected 0", scr_ov, scr_so, scr_do);
    end
    checks++;
    if (a_lv !== 1'b0 || a_ls !== 16'h0 || a_rs !== 16'h0 || d_rd !== 16'h0) begin
      errors++; $display("FAIL reset_pairs: got v %b states %h %h data %h expected 0", a_lv, a_ls, a_rs, d_rd);
    end
    rst = 1'b0;
  endtask

  task automatic test_crc_zero();
    logic [255:0] ed;
    logic [127:0] es;
    crc_si = 32'hFFFFFFFF; crc_di = 8'h00; crc_iv = 1'b1;
    model(32, 8, 128'h04C11DB7, 1'b1, 1'b0, 1'b1, 256'h0, 128'hFFFFFFFF, ed, es);
    tick();
    crc_iv = 1'b0;
    checks++;
    if (crc_ov !== 1'b1) begin errors++; $display("FAIL crc_zero_valid: got %b expected 1", crc_ov); end
    checks++;
    if (crc_so !== 32'h2DFD1072) begin errors++; $display("FAIL crc_zero_state: got %h expected 2dfd1072", crc_so); end
    checks++;
    if (crc_do !== ed[7:0]) begin errors++; $display("FAIL crc_zero_data: got %h expected %h", crc_do, ed[7:0]); end
    tick();
    checks++;
    if (crc_ov !== 1'b0) begin errors++; $display("FAIL crc_zero_valid_drop: got %b expected 0", crc_ov); end
  endtask

  task automatic test_crc_string();
    logic [31:0] st;
    logic [31:0] sw;
    logic [7:0]  b;
    st = 32'hFFFFFFFF;
    sw = 32'hFFFFFFFF;
    for (int n = 0; n < 9; n++) begin
      b = 8'h31 + 8'(n);
      crc_si = st; crc_di = b; crc_iv = 1'b1;
      sw = sw ^ {24'h0, b};
      for (int i = 0; i < 8; i++) sw = sw[0] ? ((sw >> 1) ^ 32'hEDB88320) : (sw >> 1);
      tick();
      checks++;
      if (crc_ov !== 1'b1 || crc_so !== sw) begin
        errors++; $display("FAIL crc_string_byte%0d: got v %b state %h expected v 1 state %h", n, crc_ov, crc_so, sw);
      end
      st = crc_so;
    end
    crc_iv = 1'b0;
    checks++;
    if (~st !== 32'hCBF43926) begin errors++; $display("FAIL crc_string_final: got %h expected cbf43926", ~st); end
  endtask

  task automatic test_idle_hold();
    logic [255:0] ed;
    logic [127:0] es;
    logic [31:0]  s0;
    logic [7:0]   d0;
    s0 = $urandom(); d0 = 8'($urandom());
    crc_si = s0; crc_di = d0; crc_iv = 1'b1;
    model(32, 8, 128'h04C11DB7, 1'b1, 1'b0, 1'b1, {248'h0, d0}, {96'h0, s0}, ed, es);
    tick();
    crc_iv = 1'b0;
    checks++;
    if (crc_ov !== 1'b1 || crc_so !== es[31:0] || crc_do !== ed[7:0]) begin
      errors++; $display("FAIL idle_first: got v %b state %h data %h expected v 1 state %h data %h",
                         crc_ov, crc_so, crc_do, es[31:0], ed[7:0]);
    end
    for (int c = 0; c < 5; c++) begin
      crc_si = $urandom(); crc_di = 8'($urandom());
      tick();
      checks++;
      if (crc_ov !== 1'b0 || crc_so !== es[31:0] || crc_do !== ed[7:0]) begin
        errors++; $display("FAIL idle_hold%0d: got v %b state %h data %h expected v 0 state %h data %h",
                           c, crc_ov, crc_so, crc_do, es[31:0], ed[7:0]);
      end
    end
  endtask

  task automatic test_reset_priority();
    logic [255:0] ed;
    logic [127:0] es;
    logic [7:0]   d0;
    crc_si = 32'h12345678; crc_di = 8'hA5; crc_iv = 1'b1;
    tick();
    rst = 1'b1; crc_si = 32'h9ABCDEF0; crc_di = 8'h3C; crc_iv = 1'b1;
    tick();
    checks++;
    if (crc_ov !== 1'b0 || crc_so !== 32'h0 || crc_do !== 8'h0) begin
      errors++; $display("FAIL reset_priority: got v %b state %h data %h expected all 0", crc_ov, crc_so, crc_do);
    end
    rst = 1'b0;
    d0 = 8'($urandom());
    crc_si = 32'hFFFFFFFF; crc_di = d0; crc_iv = 1'b1;
    model(32, 8, 128'h04C11DB7, 1'b1, 1'b0, 1'b1, {248'h0, d0}, 128'hFFFFFFFF, ed, es);
    tick();
    crc_iv = 1'b0;
    checks++;
    if (crc_ov !== 1'b1 || crc_so !== es[31:0] || crc_do !== ed[7:0]) begin
      errors++; $display("FAIL after_reset: got v %b state %h data %h expected v 1 state %h data %h",
                         crc_ov, crc_so, crc_do, es[31:0], ed[7:0]);
    end
  endtask

  task automatic test_scrambler();
    logic [255:0] ed;
    logic [127:0] es;
    logic [57:0]  m_state;
    logic [57:0]  d_state;
    logic [63:0]  word;
    m_state = {26'($urandom()), 32'($urandom())};
    d_state = m_state;
    for (int n = 0; n < 100; n++) begin
      word = {32'($urandom()), 32'($urandom())};
      scr_di = word; scr_si = m_state; scr_iv = 1'b1;
      model(58, 64, 128'h8000000001, 1'b0, 1'b0, 1'b0, {192'h0, word}, {70'h0, m_state}, ed, es);
      tick();
      scr_iv = 1'b0;
      checks++;
      if (scr_ov !== 1'b1 || scr_do !== ed[63:0] || scr_so !== es[57:0]) begin
        errors++; $display("FAIL scrambler%0d: got data %h state %h expected data %h state %h",
                           n, scr_do, scr_so, ed[63:0], es[57:0]);
      end
      m_state = es[57:0];
      dsc_di = scr_do; dsc_si = d_state; dsc_iv = 1'b1;
      tick();
      dsc_iv = 1'b0;
      checks++;
      if (dsc_ov !== 1'b1 || dsc_do !== word) begin
        errors++; $display("FAIL descrambler%0d: got v %b data %h expected v 1 data %h", n, dsc_ov, dsc_do, word);
      end
      d_state = dsc_so;
    end
  endtask

  task automatic test_style_match();
    logic [255:0] sd;
    logic [127:0] ss;
    logic [255:0] ed;
    logic [127:0] es;
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < 8; i++) pd[i*32 +: 32] = $urandom();
      for (int i = 0; i < 4; i++) ps[i*32 +: 32] = $urandom();
      pv = 1'b1;
      sd = pd; ss = ps;
      tick();
      model(16, 8, 128'h1021, 1'b1, 1'b0, 1'b0, sd, ss, ed, es);
      checks++;
      if ({a_lv, a_ld, a_ls} !== {a_rv, a_rd, a_rs} || a_lv !== 1'b1 || a_ld !== ed[7:0] || a_ls !== es[15:0]) begin
        errors++; $display("FAIL style_galois_fwd%0d: loop %h/%h red %h/%h expected %h/%h",
                           n, a_ld, a_ls, a_rd, a_rs, ed[7:0], es[15:0]);
      end
      model(32, 24, 128'h04C11DB7, 1'b1, 1'b0, 1'b1, sd, ss, ed, es);
      checks++;
      if ({b_lv, b_ld, b_ls} !== {b_rv, b_rd, b_rs} || b_lv !== 1'b1 || b_ld !== ed[23:0] || b_ls !== es[31:0]) begin
        errors++; $display("FAIL style_galois_rev%0d: loop %h/%h red %h/%h expected %h/%h",
                           n, b_ld, b_ls, b_rd, b_rs, ed[23:0], es[31:0]);
      end
      model(7, 12, 128'h41, 1'b0, 1'b0, 1'b0, sd, ss, ed, es);
      checks++;
      if ({c_lv, c_ld, c_ls} !== {c_rv, c_rd, c_rs} || c_lv !== 1'b1 || c_ld !== ed[11:0] || c_ls !== es[6:0]) begin
        errors++; $display("FAIL style_fib_fwd%0d: loop %h/%h red %h/%h expected %h/%h",
                           n, c_ld, c_ls, c_rd, c_rs, ed[11:0], es[6:0]);
      end
      model(23, 16, 128'h21, 1'b0, 1'b1, 1'b1, sd, ss, ed, es);
      checks++;
      if ({d_lv, d_ld, d_ls} !== {d_rv, d_rd, d_rs} || d_lv !== 1'b1 || d_ld !== ed[15:0] || d_ls !== es[22:0]) begin
        errors++; $display("FAIL style_fib_rev%0d: loop %h/%h red %h/%h expected %h/%h",
                           n, d_ld, d_ls, d_rd, d_rs, ed[15:0], es[22:0]);
      end
    end
    pv = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    crc_iv = 1'b0; crc_di = '0; crc_si = '0;
    scr_iv = 1'b0; scr_di = '0; scr_si = '0;
    dsc_iv = 1'b0; dsc_di = '0; dsc_si = '0;
    pv = 1'b0; pd = '0; ps = '0;
    #1;
    test_reset();
    test_crc_zero();
    test_crc_string();
    test_idle_hold();
    test_reset_priority();
    test_scrambler();
    test_style_match();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
